// File: rtl/div_pkg.sv
// Shared types and default widths for the shared restoring-divider scheduler.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_DW = 6;
    localparam int DIV_VW = 3;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
module div_step #(
    parameter int VW = 3
) (
    input  logic [VW:0]   rem_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    // One guard bit above the partial remainder keeps the compare/subtract exact.
    logic [VW+1:0] shifted;
    logic [VW+1:0] div_ext;

    always_comb begin
        shifted = {rem_in, bit_in};
        div_ext = {2'b00, divisor};
        q_bit   = (shifted >= div_ext);
        rem_out = (VW+1)'(q_bit ? (shifted - div_ext) : shifted);
    end

endmodule

// File: rtl/div_sched.sv
// Arbitrates NREQ requesters onto one iterative restoring divider with a tagged response port.
// Define DIV_SCHED_RR_EN for round-robin arbitration; otherwise lowest valid index wins.
module div_sched
    import div_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int DW   = DIV_DW,
    parameter  int VW   = DIV_VW,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_dividend,
    input  logic [NREQ*VW-1:0] req_divisor,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_quotient,
    output logic [VW-1:0]      rsp_remainder,
    output logic               rsp_div0,
    output logic               busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    div_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dq_q;
    logic [VW:0]   rem_q;
    logic [VW-1:0] dvs_q;
    logic [IDW-1:0] id_q;
    logic          div0_q;
    logic          rsp_valid_q;
    logic          busy_q;

    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [DW-1:0]  sel_a;
    logic [VW-1:0]  sel_b;
    logic [VW:0]    step_rem;
    logic           step_q;

`ifdef DIV_SCHED_RR_EN
    logic [IDW-1:0] ptr_q;
    int unsigned    cand;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(cand);
            end
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        sel_a     = req_dividend[gnt_idx*DW +: DW];
        sel_b     = req_divisor[gnt_idx*VW +: VW];
        req_ready = '0;
        if (state_q == IDLE && gnt_any) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
        end
    end

    // The dividend register doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
    div_step #(.VW(VW)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dq_q[DW-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            id_q        <= '0;
            div0_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DIV_SCHED_RR_EN
            ptr_q       <= IDW'(NREQ - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        id_q   <= gnt_idx;
                        dvs_q  <= sel_b;
                        busy_q <= 1'b1;
`ifdef DIV_SCHED_RR_EN
                        ptr_q  <= gnt_idx;
`endif
                        if (sel_b == '0) begin
                            state_q     <= DONE;
                            dq_q        <= '1;
                            rem_q       <= {1'b0, sel_a[VW-1:0]};
                            div0_q      <= 1'b1;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= CW'(DW - 1);
                            dq_q    <= sel_a;
                            rem_q   <= '0;
                            div0_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    dq_q  <= (dq_q << 1) | DW'(step_q);
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = id_q;
    assign rsp_quotient  = dq_q;
    assign rsp_remainder = rem_q[VW-1:0];
    assign rsp_div0      = div0_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: arithmetic reference model, directed cases plus random traffic.
module tb_div_sched;

    localparam int NREQ = 2;
    localparam int DW   = 6;
    localparam int VW   = 3;
    localparam int IDW  = 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_dividend = '0;
    logic [NREQ*VW-1:0] req_divisor = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_quotient;
    logic [VW-1:0]      rsp_remainder;
    logic               rsp_div0;
    logic               busy;

    div_sched #(.NREQ(NREQ), .DW(DW), .VW(VW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div0      (rsp_div0),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int q;
        int r;
        int d0;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   acc_ids[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_count = 0;
    bit   model_busy = 1'b0;
    int   model_ptr = NREQ - 1;
    bit   rsp_seen = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
`ifdef DIV_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (v[k] && p >= -1) return k;
`endif
        return -1;
    endfunction

    // Monitor: predicts grants and busy, pushes expected results on accept, compares responses.
    always @(negedge clk) begin : mon
        int   g;
        int   a;
        int   b;
        exp_t e;
        if (!rst_n) begin
            check_eq("reset_outputs",
                     {req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0, busy}, 0);
            sb.delete();
            model_busy = 1'b0;
            model_ptr  = NREQ - 1;
            rsp_seen   = 1'b0;
        end else begin
            g = model_busy ? -1 : pick(req_valid, model_ptr);
            check_eq("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
            check_eq("busy", busy, model_busy);
            if (!rsp_seen && sb.size() > 0 && (rsp_valid || cyc >= sb[0].cyc)) begin
                check_eq("rsp_latency", rsp_valid ? cyc : -1, sb[0].cyc);
                rsp_seen = 1'b1;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_spurious", rsp_valid, 0);
                end else begin
                    check_eq("rsp_id", rsp_id, sb[0].id);
                    check_eq("rsp_quotient", rsp_quotient, sb[0].q);
                    check_eq("rsp_remainder", rsp_remainder, sb[0].r);
                    check_eq("rsp_div0", rsp_div0, sb[0].d0);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        model_busy = 1'b0;
                        rsp_seen   = 1'b0;
                    end
                end
            end
            if (g >= 0) begin
                a     = int'(req_dividend[g*DW +: DW]);
                b     = int'(req_divisor[g*VW +: VW]);
                e.id  = g;
                e.d0  = (b == 0) ? 1 : 0;
                e.q   = (b == 0) ? (1 << DW) - 1 : a / b;
                e.r   = (b == 0) ? a % (1 << VW) : a % b;
                e.cyc = cyc + ((b == 0) ? 1 : DW + 1);
                sb.push_back(e);
                model_busy = 1'b1;
                model_ptr  = g;
                acc_ids.push_back(g);
                acc_count++;
            end
        end
    end

    task automatic issue(input int i, input int a, input int b);
        bit ok;
        @(posedge clk); #1;
        req_dividend[i*DW +: DW] = DW'(a);
        req_divisor[i*VW +: VW]  = VW'(b);
        req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("issue_accepted", ok, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("idle_timeout", ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int base;
        int exp_ids[3];
        bit ok;
        logic [NREQ-1:0] acc;
`ifdef DIV_SCHED_RR_EN
        exp_ids = '{0, 1, 0};
`else
        exp_ids = '{0, 0, 0};
`endif
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(0, 45, 6);
        wait_idle();
        issue(1, 63, 1);
        wait_idle();
        issue(1, 5, 7);
        wait_idle();
        issue(0, 6, 0);
        wait_idle();

        // Both requesters held valid across three operations.
        do_reset();
        @(posedge clk); #1;
        req_dividend[0*DW +: DW] = 6'd40;
        req_divisor[0*VW +: VW]  = 3'd5;
        req_dividend[1*DW +: DW] = 6'd33;
        req_divisor[1*VW +: VW]  = 3'd4;
        req_valid = '1;
        base = acc_ids.size();
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            if (acc_ids.size() >= base + 3) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        req_valid = '0;
        check_eq("arb_three_accepts", ok, 1);
        for (int k = 0; k < 3; k++)
            if (acc_ids.size() > base + k) check_eq("arb_id", acc_ids[base + k], exp_ids[k]);
        wait_idle();

        // Consumer stalls for 5 cycles in DONE while requester 1 waits.
        rsp_ready = 1'b0;
        issue(0, 45, 6);
        @(posedge clk); #1;
        req_dividend[1*DW +: DW] = 6'd20;
        req_divisor[1*VW +: VW]  = 3'd3;
        req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("stall_rsp_seen", ok, 1);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        base = acc_count;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            if (acc_count > base) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        req_valid[1] = 1'b0;
        check_eq("stall_followup_accept", ok, 1);
        wait_idle();

        // Reset during the third RUN step discards the operation.
        issue(0, 50, 7);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("no_rsp_after_reset", rsp_valid, 0);
        issue(0, 50, 7);
        wait_idle();

        // Random traffic with random consumer backpressure.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                if (!req_valid[i] && !acc[i] && $urandom_range(0, 3) == 0) begin
                    req_dividend[i*DW +: DW] = DW'($urandom_range(0, 63));
                    req_divisor[i*VW +: VW]  = VW'($urandom_range(0, 7));
                    req_valid[i] = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        check_eq("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
